// File: rtl/switch_debounce4.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : switch_debounce4                                             |
// | Description : Four-channel switch conditioner. Each raw switch level goes  |
// |               through a two-flop synchroniser and an independent debounce  |
// |               FSM. The FSM drives a clean level x1..x4 and a one-cycle     |
// |               change pulse per channel, plus a combined change flag.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module switch_debounce4 #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sw_raw,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       x4,
  output logic [3:0] chg_mask,
  output logic       changed
);

  // Count value on which a persistent mismatch is finally accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_x;
  logic [3:0] w_fire;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_chan
      state_t           r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_out;
      logic             r_pulse;

      // The channel accepts its new level on this edge.
      assign w_fire[i] = (r_state == ST_PENDING) && (r_sync2[i] != r_out) &&
                         (r_cnt == CNT_LAST);
      assign w_x[i]      = r_out;
      assign chg_mask[i] = r_pulse;

      // Debounce FSM: the output follows only after an unbroken run of mismatches.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          assert (32'(r_cnt) < STABLE_CYCLES);
          r_pulse <= 1'b0;
          case (r_state)
            ST_STABLE: begin
              r_cnt <= '0;
              if (r_sync2[i] != r_out) begin
                r_state <= ST_PENDING;
                r_cnt   <= CNT_W'(1);
              end
            end
            ST_PENDING: begin
              if (r_sync2[i] == r_out) begin
                // Glitch ended before the run completed: discard it.
                r_state <= ST_STABLE;
                r_cnt   <= '0;
              end else if (w_fire[i]) begin
                r_out   <= r_sync2[i];
                r_pulse <= 1'b1;
                r_cnt   <= '0;
                r_state <= ST_STABLE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // Combined change flag, aligned with the per-channel pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |w_fire;
    end
  end

  assign x1 = w_x[0];
  assign x2 = w_x[1];
  assign x3 = w_x[2];
  assign x4 = w_x[3];

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce4.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_switch_debounce4                                          |
// | Description : Self-checking bench for switch_debounce4. A window-based     |
// |               reference model predicts level changes and pushes them into |
// |               a scoreboard queue; a monitor pops on every changed pulse.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_switch_debounce4;

  localparam int STABLE = 16;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_raw;
  logic       x1, x2, x3, x4;
  logic [3:0] chg_mask;
  logic       changed;

  switch_debounce4 #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_raw  (sw_raw),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .x4      (x4),
    .chg_mask(chg_mask),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] m;
    int         cyc;
  } exp_t;

  exp_t       expq[$];
  bit   [3:0] rq[$];    // raw levels captured on each edge since reset release
  bit   [3:0] s2h[$];   // synchronised level seen on each of the last STABLE edges
  logic [3:0] mx;       // model debounced levels
  int         cyc;
  int         checks;
  int         errors;

  // Reference model: a channel flips once its synchronised level has
  // disagreed with the current output on each of the last STABLE edges.
  always @(posedge clk or negedge reset_n) begin
    bit   [3:0] s2;
    logic [3:0] fire;
    bit         all;
    if (!reset_n) begin
      rq.delete();
      s2h.delete();
      expq.delete();
      mx = 4'b0000;
    end else begin
      cyc++;
      s2 = (rq.size() >= 2) ? rq[rq.size()-2] : 4'b0000;
      rq.push_back(sw_raw);
      if (rq.size() > 4) void'(rq.pop_front());
      s2h.push_back(s2);
      if (s2h.size() > STABLE) void'(s2h.pop_front());
      fire = 4'b0000;
      if (s2h.size() == STABLE) begin
        for (int i = 0; i < 4; i++) begin
          all = 1'b1;
          foreach (s2h[j]) if (s2h[j][i] == mx[i]) all = 1'b0;
          fire[i] = all;
        end
      end
      if (fire != 4'b0000) begin
        mx = mx ^ fire;
        expq.push_back('{x: mx, m: fire, cyc: cyc});
      end
    end
  end

  // Monitor: levels every cycle, scoreboard pop on every changed pulse.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] xv;
    xv = {x4, x3, x2, x1};
    if (!reset_n) begin
      checks++;
      if (xv !== 4'b0000 || chg_mask !== 4'b0000 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: x=%b chg_mask=%b changed=%b, required all 0",
                 xv, chg_mask, changed);
      end
    end else begin
      checks++;
      if (xv !== mx) begin
        errors++;
        $display("FAIL level cyc=%0d: x=%b, required %b", cyc, xv, mx);
      end
      checks++;
      if ((chg_mask !== 4'b0000) !== changed) begin
        errors++;
        $display("FAIL changed_vs_mask cyc=%0d: changed=%b chg_mask=%b", cyc, changed, chg_mask);
      end
      if (changed === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d: chg_mask=%b, required no pulse", cyc, chg_mask);
        end else begin
          e = expq.pop_front();
          if (e.cyc != cyc || e.m !== chg_mask || e.x !== xv) begin
            errors++;
            $display("FAIL pulse cyc=%0d: x=%b mask=%b, required x=%b mask=%b at cyc %0d",
                     cyc, xv, chg_mask, e.x, e.m, e.cyc);
          end
        end
      end
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: no pulse observed, required mask=%b at cyc %0d", e.m, e.cyc);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    @(negedge clk);
    sw_raw = v;
    hold(n - 1);
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if ({x4, x3, x2, x1} !== 4'b0000 || chg_mask !== 4'b0000 || changed !== 1'b0) begin
      errors++;
      $display("FAIL %s: x=%b chg_mask=%b changed=%b, required all 0",
               name, {x4, x3, x2, x1}, chg_mask, changed);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lens[3];
    bit b[6];
    lens = '{10, 15, 16};
    b    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    reset_n = 1'b0;
    sw_raw  = 4'b0000;
    hold(3);
    reset_n = 1'b1;

    drive(4'b0000, 40);
    drive(4'b0001, 25);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0101, lens[k]);
      drive(4'b0001, 40);
    end
    drive(4'b0000, 25);
    drive(4'b1010, 25);
    drive(4'b0010, 25);
    for (int k = 0; k < 6; k++) drive({b[k], 3'b010}, 1);
    hold(25);

    for (int k = 0; k < 300; k++) drive(4'($urandom), $urandom_range(1, 24));

    // Reset with all outputs high: must clear without waiting for a clock.
    drive(4'b1111, 25);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_cleared("async_clear_high");
    hold(3);
    reset_n = 1'b1;
    hold(25);
    // Reset while every channel is mid-count, then release with switches held.
    drive(4'b0000, 25);
    drive(4'b1111, 9);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_cleared("async_clear_pending");
    hold(3);
    reset_n = 1'b1;
    hold(30);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected pulses not seen, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
